// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared chip8 constants, loader state type and the hex fontset
package chip8_pkg;

    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 8;

    // Fontset geometry: 16 glyphs of 5 bytes, indexed by a 7-bit counter.
    localparam int FONT_BYTES = 80;
    localparam int FONT_IDX_W = 7;

    // Byte counter is one bit wider than the address so a full-memory
    // image plus dropped bytes is still representable before saturating.
    localparam int BYTE_CNT_W = MEM_ADDR_W + 1;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_FONT = 2'd1,
        LD_PROG = 2'd2,
        LD_DONE = 2'd3
    } loader_state_e;

    // Standard 0-F glyphs; each row's high nibble is the 4-pixel-wide sprite.
    localparam logic [MEM_DATA_W-1:0] FONTSET [0:FONT_BYTES-1] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,   // 0
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,   // 1
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,   // 2
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,   // 3
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,   // 4
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,   // 5
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,   // 6
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,   // 7
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,   // 8
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,   // 9
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,   // A
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,   // B
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,   // C
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,   // D
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,   // E
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80    // F
    };

    // Out-of-range indices read as zero so the lookup is total over 7 bits.
    function automatic logic [MEM_DATA_W-1:0] font_byte(input logic [FONT_IDX_W-1:0] idx);
        if (int'(idx) < FONT_BYTES) begin
            return FONTSET[idx];
        end
        return '0;
    endfunction

endpackage

// File: rtl/chip8_loader.sv
// rtl/chip8_loader.sv - boot loader: fontset then streamed ROM image into memory, holds CPU until done
module chip8_loader
    import chip8_pkg::*;
#(
    parameter logic [MEM_ADDR_W-1:0] FONT_BASE = 12'h000,
    parameter logic [MEM_ADDR_W-1:0] PROG_BASE = 12'h200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [MEM_DATA_W-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_write_addr,
    output logic [MEM_DATA_W-1:0] mem_write_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [BYTE_CNT_W-1:0] byte_count
);

    localparam logic [BYTE_CNT_W-1:0] CNT_MAX = '1;

    loader_state_e         state_q, state_d;
    logic [FONT_IDX_W-1:0] font_idx_q, font_idx_d;
    // One extra bit: bit MEM_ADDR_W set means the top address was already written.
    logic [MEM_ADDR_W:0]   addr_q, addr_d;
    logic                  ovf_q, ovf_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [MEM_ADDR_W-1:0] wa_q, wa_d;
    logic [MEM_DATA_W-1:0] wd_q, wd_d;
    logic                  accept;

    // Handshake qualifier; in_ready depends on registered state only.
    assign in_ready = (state_q == LD_PROG);
    assign accept   = in_valid & in_ready;

    // Next-state and write-port decode; write strobe defaults low every cycle.
    always_comb begin
        state_d    = state_q;
        font_idx_d = font_idx_q;
        addr_d     = addr_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        wr_d       = 1'b0;
        wa_d       = wa_q;
        wd_d       = wd_q;

        case (state_q)
            LD_IDLE, LD_DONE: begin
                // Font byte 0 is issued on the same edge that accepts start.
                if (start) begin
                    state_d    = LD_FONT;
                    wr_d       = 1'b1;
                    wa_d       = FONT_BASE;
                    wd_d       = font_byte('0);
                    font_idx_d = FONT_IDX_W'(1);
                    addr_d     = {1'b0, PROG_BASE};
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                end
            end

            LD_FONT: begin
                if (int'(font_idx_q) == FONT_BYTES) begin
                    state_d = LD_PROG;
                end else begin
                    wr_d       = 1'b1;
                    wa_d       = FONT_BASE + MEM_ADDR_W'(font_idx_q);
                    wd_d       = font_byte(font_idx_q);
                    font_idx_d = font_idx_q + FONT_IDX_W'(1);
                end
            end

            LD_PROG: begin
                if (accept) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + BYTE_CNT_W'(1);
                    end
                    // Past the top of memory: keep draining but drop the byte.
                    if (addr_q[MEM_ADDR_W]) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_d   = 1'b1;
                        wa_d   = addr_q[MEM_ADDR_W-1:0];
                        wd_d   = in_data;
                        addr_d = addr_q + (MEM_ADDR_W+1)'(1);
                    end
                    if (in_last) begin
                        state_d = LD_DONE;
                    end
                end
            end

            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    // State and registered write port; reset abandons any partial image.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LD_IDLE;
            font_idx_q <= '0;
            addr_q     <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            font_idx_q <= font_idx_d;
            addr_q     <= addr_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
        end
    end

    assign mem_write      = wr_q;
    assign mem_write_addr = wa_q;
    assign mem_write_data = wd_q;
    assign cpu_hold       = (state_q != LD_DONE);
    assign busy           = (state_q == LD_FONT) || (state_q == LD_PROG);
    assign done           = (state_q == LD_DONE);
    assign error          = (state_q == LD_DONE) && ovf_q;
    assign byte_count     = cnt_q;

endmodule

// File: doc/chip8_loader.md
# chip8_loader

Boot-time program loader that is the write-side counterpart of the chip8 memory read path. It owns the memory write port (`mem_write`, `mem_write_addr`, `mem_write_data`) while the CPU is held. On `start` it first writes the 80-byte hex fontset into low memory, then streams a ROM image from a byte-wide valid/ready source into memory starting at the program base. When done it releases `cpu_hold` so the CPU begins fetching.

## Interface
Parameters:
- FONT_BASE, 12'h000, first address of the 80-byte fontset.
- PROG_BASE, 12'h200, first address of the program image.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle load request; honoured only in IDLE or DONE.
- in_valid  in  1  source byte valid.
- in_data  in  8  source byte.
- in_last  in  1  qualifies the final byte of the image.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_write  out  1  memory write strobe, one byte per cycle.
- mem_write_addr  out  12  write address.
- mem_write_data  out  8  write data.
- cpu_hold  out  1  high while the CPU must not run.
- busy  out  1  high in FONT and PROG.
- done  out  1  high in DONE.
- error  out  1  image overflowed memory; valid while done=1.
- byte_count  out  13  program bytes accepted in the last load, including dropped bytes.

## Operation
States:
- IDLE:
  - Reset state. cpu_hold=1. in_ready=0.
  - start moves to FONT.
- FONT:
  - Writes fontset byte i to FONT_BASE+i, for i = 0..79, one per cycle.
  - After i=79 is issued, moves to PROG.
  - in_ready=0.
- PROG:
  - in_ready=1. A byte is accepted on any cycle with in_valid & in_ready.
  - Each accepted byte is written to the current address, and the address increments.
  - Address starts at PROG_BASE.
  - Overflow: if a byte is accepted after address 12'hFFF has already been written, that byte is dropped (no mem_write) and a sticky overflow flag is set. in_ready stays 1 so the source drains.
  - An accepted byte with in_last=1 moves to DONE.
- DONE:
  - cpu_hold=0, done=1, error = overflow flag.
  - start re-enters FONT and clears byte_count and the overflow flag.

Other rules:
- byte_count saturates at 13'h1FFF.
- Address arithmetic is 12-bit. Overflow is detected via the 13th carry bit, never by silent wrap.
- start is ignored in FONT and PROG.
- An in_last beat is the final byte and is written (unless dropped by overflow).

## Timing
- Reset values: state IDLE, mem_write=0, mem_write_addr=0, mem_write_data=0, in_ready=0, cpu_hold=1, busy=0, done=0, error=0, byte_count=0.
- mem_write, mem_write_addr and mem_write_data are registered.
- start sampled in cycle T → mem_write=1 with addr FONT_BASE in cycle T+1.
- The last font write is in cycle T+80. in_ready rises in cycle T+81.
- in_ready is decoded from registered state only, with no combinational path from in_valid.
- Byte accepted in cycle N → mem_write=1 with that address and data in cycle N+1. Back-to-back acceptance gives one write per cycle.
- in_last accepted in cycle N:
  - In cycle N+1: DONE, done=1, cpu_hold=0, and the last write is visible.
  - In_ready=0 from cycle N+1.
- rst mid-load: in the next cycle state is IDLE and mem_write=0. A partially written image is abandoned, with no completion write.
- Throughput: 80 + L cycles for an L-byte image with continuous in_valid.

## Structure
- Shared package `chip8_pkg` holds:
  - FONTSET: an 80-entry × 8-bit constant array with the standard 0–F glyphs, 5 bytes each, starting F0 90 90 90 F0.
  - The FONT_BYTES=80 constant.
  - The loader state enum.
  - The MEM_ADDR_W=12 and MEM_DATA_W=8 constants.
- No sub-module. The fontset is a case/array lookup indexed by the 7-bit font counter.
- In chip8 top, the loader drives the memory write port. cpu_hold gates the CPU tick.

## Test plan
- Reset, then start:
  - mem_write at cycles 1..80 with addr 0x000..0x04F.
  - Data 0xF0 at 0x000, 0x80 at 0x04F.
  - in_ready rises at cycle 81.
- 4-byte image 12 34 56 78, continuous valid, last on 0x78:
  - Writes at 0x200..0x203.
  - done=1 and cpu_hold=0 one cycle after the 0x78 accept.
  - byte_count=4, error=0.
- Valid toggling every other cycle: writes occur only the cycle after each handshake, and addresses stay contiguous.
- Image of 3586 bytes:
  - Last write at 0xFFF.
  - 2 bytes dropped with no write.
  - error=1, byte_count=3586.
- rst asserted in PROG after 10 bytes:
  - Next cycle IDLE, mem_write=0, cpu_hold=1.
  - A new start restarts the fontset at 0x000.
- start pulsed during FONT is ignored (no restart). start in DONE reloads, and error/byte_count clear.
